// File: rtl/tdm_demux4_pkg.sv
// Shared definitions for the 4-slot TDM demultiplexer.
package tdm_demux4_pkg;

   localparam int unsigned NSLOT  = 4;
   localparam int unsigned SLOT_W = 2;
   localparam int unsigned ERR_W  = 8;

   typedef enum logic {
      ST_HUNT = 1'b0,
      ST_LOCK = 1'b1
   } state_e;

endpackage

// File: rtl/tdm_slot_decode.sv
// One-hot decode of a slot index, gated by accept. Drives both the slot
// strobe and the staging register write enables.
module tdm_slot_decode
   import tdm_demux4_pkg::*;
(
   input  logic [SLOT_W-1:0] slot,
   input  logic              accept,
   output logic [NSLOT-1:0]  onehot
);

   // Single bit set for the accepted slot, none otherwise.
   always_comb begin
      onehot = '0;
      if (accept) onehot[slot] = 1'b1;
   end

endmodule

// File: rtl/tdm_demux4.sv
// Receive side of a 4-slot TDM link: finds frame alignment from the sync
// marker, stages slots 0..2 and publishes a whole frame when slot 3 lands.
// Optional error counter enabled by defining TDM_ERR_CNT_EN.
module tdm_demux4
   import tdm_demux4_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic                   in_sync,
   input  logic [WIDTH-1:0]       in_data,
   output logic [WIDTH-1:0]       slot_data,
   output logic [NSLOT-1:0]       slot_valid,
   output logic [NSLOT*WIDTH-1:0] frame_data,
   output logic                   frame_valid,
   output logic                   locked,
   output logic [SLOT_W-1:0]      cur_slot,
   output logic                   sync_err,
   output logic [ERR_W-1:0]       err_cnt
);

   state_e                 state_q, state_d;
   logic [SLOT_W-1:0]      cur_slot_q, cur_slot_d;
   logic [WIDTH-1:0]       stage_q [NSLOT-1];
   logic [WIDTH-1:0]       stage_d [NSLOT-1];
   logic [WIDTH-1:0]       slot_data_q, slot_data_d;
   logic [NSLOT-1:0]       slot_valid_q;
   logic [NSLOT*WIDTH-1:0] frame_data_q, frame_data_d;
   logic                   frame_valid_q, frame_valid_d;
   logic                   sync_err_q, sync_err_d;

   logic                   accept;
   logic [SLOT_W-1:0]      cap_slot;
   logic [NSLOT-1:0]       slot_we;

   // Alignment FSM: decides whether and where a beat is captured.
   always_comb begin
      state_d       = state_q;
      cur_slot_d    = cur_slot_q;
      frame_data_d  = frame_data_q;
      frame_valid_d = 1'b0;
      sync_err_d    = 1'b0;
      accept        = 1'b0;
      // A sync beat always restarts the frame at slot 0.
      cap_slot      = in_sync ? '0 : cur_slot_q;
      if (in_valid) begin
         if (state_q == ST_HUNT) begin
            if (in_sync) begin
               accept     = 1'b1;
               cur_slot_d = SLOT_W'(1);
               state_d    = ST_LOCK;
            end
         end else if (in_sync) begin
            // Early sync drops the partial frame but stays locked.
            accept     = 1'b1;
            cur_slot_d = SLOT_W'(1);
            sync_err_d = (cur_slot_q != '0);
         end else if (cur_slot_q == '0) begin
            sync_err_d = 1'b1;
            cur_slot_d = '0;
            state_d    = ST_HUNT;
         end else begin
            accept     = 1'b1;
            cur_slot_d = cur_slot_q + SLOT_W'(1);
            if (cur_slot_q == SLOT_W'(NSLOT - 1)) begin
               frame_valid_d = 1'b1;
               frame_data_d  = {in_data, stage_q[2], stage_q[1], stage_q[0]};
            end
         end
      end
   end

   tdm_slot_decode u_slot_decode (
      .slot   (cap_slot),
      .accept (accept),
      .onehot (slot_we)
   );

   // Data path: staging writes and last-beat payload.
   always_comb begin
      stage_d     = stage_q;
      slot_data_d = slot_data_q;
      if (accept) slot_data_d = in_data;
      for (int s = 0; s < NSLOT - 1; s++) begin
         if (slot_we[s]) stage_d[s] = in_data;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_HUNT;
         cur_slot_q    <= '0;
         slot_data_q   <= '0;
         slot_valid_q  <= '0;
         frame_data_q  <= '0;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
         for (int s = 0; s < NSLOT - 1; s++) stage_q[s] <= '0;
      end else begin
         state_q       <= state_d;
         cur_slot_q    <= cur_slot_d;
         slot_data_q   <= slot_data_d;
         slot_valid_q  <= slot_we;
         frame_data_q  <= frame_data_d;
         frame_valid_q <= frame_valid_d;
         sync_err_q    <= sync_err_d;
         stage_q       <= stage_d;
      end
   end

`ifdef TDM_ERR_CNT_EN
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   // Saturating count, bumped in step with the sync_err pulse.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (sync_err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_W'(1);
   end

   // Error counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_cnt_q <= '0;
      else     err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = '0;
`endif

   assign slot_data   = slot_data_q;
   assign slot_valid  = slot_valid_q;
   assign frame_data  = frame_data_q;
   assign frame_valid = frame_valid_q;
   assign locked      = (state_q == ST_LOCK);
   assign cur_slot    = cur_slot_q;
   assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: the driver queues the expected response
// of each beat that should produce a strobe; the monitor pops and compares.
module tb_tdm_demux4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_sync = 1'b0;
   logic [7:0]  in_data = '0;
   logic [7:0]  slot_data;
   logic [3:0]  slot_valid;
   logic [31:0] frame_data;
   logic        frame_valid;
   logic        locked;
   logic [1:0]  cur_slot;
   logic        sync_err;
   logic [7:0]  err_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0]  sd;
      logic [3:0]  sv;
      logic        fv;
      logic [31:0] fd;
      logic        err;
      logic        lk;
      logic [1:0]  cur;
   } exp_t;

   exp_t sb[$];

   tdm_demux4 #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_sync     (in_sync),
      .in_data     (in_data),
      .slot_data   (slot_data),
      .slot_valid  (slot_valid),
      .frame_data  (frame_data),
      .frame_valid (frame_valid),
      .locked      (locked),
      .cur_slot    (cur_slot),
      .sync_err    (sync_err),
      .err_cnt     (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Drive one beat; queue the expected response if it should be visible.
   task automatic beat(input logic [7:0] d, input logic s, input logic [3:0] sv,
                       input logic fv, input logic [31:0] fd, input logic err,
                       input logic lk, input logic [1:0] cur);
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      in_sync  = s;
      in_data  = d;
      if (sv != 4'b0 || fv || err) begin
         e.sd = d; e.sv = sv; e.fv = fv; e.fd = fd; e.err = err; e.lk = lk; e.cur = cur;
         sb.push_back(e);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_sync  = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".slot_valid"},  {28'b0, slot_valid}, 32'h0);
      chk({tag, ".slot_data"},   {24'b0, slot_data},  32'h0);
      chk({tag, ".frame_data"},  frame_data,          32'h0);
      chk({tag, ".frame_valid"}, {31'b0, frame_valid}, 32'h0);
      chk({tag, ".locked"},      {31'b0, locked},     32'h0);
      chk({tag, ".cur_slot"},    {30'b0, cur_slot},   32'h0);
      chk({tag, ".sync_err"},    {31'b0, sync_err},   32'h0);
      chk({tag, ".err_cnt"},     {24'b0, err_cnt},    32'h0);
   endtask

   // Monitor: any strobe must match the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (slot_valid != 4'b0 || frame_valid || sync_err) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: sv=%b fv=%b err=%b expected none",
                        slot_valid, frame_valid, sync_err);
            end else begin
               e = sb.pop_front();
               chk("slot_valid",  {28'b0, slot_valid},  {28'b0, e.sv});
               chk("frame_valid", {31'b0, frame_valid}, {31'b0, e.fv});
               chk("frame_data",  frame_data,           e.fd);
               chk("sync_err",    {31'b0, sync_err},    {31'b0, e.err});
               chk("locked",      {31'b0, locked},      {31'b0, e.lk});
               chk("cur_slot",    {30'b0, cur_slot},    {30'b0, e.cur});
               if (e.sv != 4'b0) chk("slot_data", {24'b0, slot_data}, {24'b0, e.sd});
            end
         end
      end
   end

   initial begin
      #3;
      chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Basic aligned frame.
      beat(8'hA1, 1, 4'b0001, 0, 32'h0, 0, 1, 2'd1);
      beat(8'hB2, 0, 4'b0010, 0, 32'h0, 0, 1, 2'd2);
      beat(8'hC3, 0, 4'b0100, 0, 32'h0, 0, 1, 2'd3);
      beat(8'hD4, 0, 4'b1000, 1, 32'hD4C3B2A1, 0, 1, 2'd0);
      // Missing sync after a complete frame: error, back to HUNT.
      beat(8'h55, 0, 4'b0000, 0, 32'hD4C3B2A1, 1, 0, 2'd0);
      // HUNT drops non-sync beats silently.
      beat(8'h11, 0, 4'b0000, 0, 32'hD4C3B2A1, 0, 0, 2'd0);
      beat(8'h22, 0, 4'b0000, 0, 32'hD4C3B2A1, 0, 0, 2'd0);
      idle();
      #2;
      chk("hunt.locked",   {31'b0, locked},   32'h0);
      chk("hunt.cur_slot", {30'b0, cur_slot}, 32'h0);
      beat(8'h33, 1, 4'b0001, 0, 32'hD4C3B2A1, 0, 1, 2'd1);
      beat(8'h34, 0, 4'b0010, 0, 32'hD4C3B2A1, 0, 1, 2'd2);
      beat(8'h35, 0, 4'b0100, 0, 32'hD4C3B2A1, 0, 1, 2'd3);
      beat(8'h36, 0, 4'b1000, 1, 32'h36353433, 0, 1, 2'd0);
      // Early sync restarts the frame.
      beat(8'h01, 1, 4'b0001, 0, 32'h36353433, 0, 1, 2'd1);
      beat(8'h02, 0, 4'b0010, 0, 32'h36353433, 0, 1, 2'd2);
      beat(8'h03, 1, 4'b0001, 0, 32'h36353433, 1, 1, 2'd1);
      beat(8'h04, 0, 4'b0010, 0, 32'h36353433, 0, 1, 2'd2);
      beat(8'h05, 0, 4'b0100, 0, 32'h36353433, 0, 1, 2'd3);
      beat(8'h06, 0, 4'b1000, 1, 32'h06050403, 0, 1, 2'd0);
      // Gapped beats.
      beat(8'h71, 1, 4'b0001, 0, 32'h06050403, 0, 1, 2'd1);
      idle();
      beat(8'h72, 0, 4'b0010, 0, 32'h06050403, 0, 1, 2'd2);
      idle();
      beat(8'h73, 0, 4'b0100, 0, 32'h06050403, 0, 1, 2'd3);
      idle();
      beat(8'h74, 0, 4'b1000, 1, 32'h74737271, 0, 1, 2'd0);
      // Back-to-back frame.
      beat(8'h81, 1, 4'b0001, 0, 32'h74737271, 0, 1, 2'd1);
      beat(8'h82, 0, 4'b0010, 0, 32'h74737271, 0, 1, 2'd2);
      beat(8'h83, 0, 4'b0100, 0, 32'h74737271, 0, 1, 2'd3);
      beat(8'h84, 0, 4'b1000, 1, 32'h84838281, 0, 1, 2'd0);
      // Asynchronous reset mid-frame.
      beat(8'h91, 1, 4'b0001, 0, 32'h84838281, 0, 1, 2'd1);
      beat(8'h92, 0, 4'b0010, 0, 32'h84838281, 0, 1, 2'd2);
      idle();
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      beat(8'h93, 0, 4'b0000, 0, 32'h0, 0, 0, 2'd0);
      beat(8'hA5, 1, 4'b0001, 0, 32'h0, 0, 1, 2'd1);
      beat(8'hB6, 0, 4'b0010, 0, 32'h0, 0, 1, 2'd2);
      beat(8'hC7, 0, 4'b0100, 0, 32'h0, 0, 1, 2'd3);
      beat(8'hD8, 0, 4'b1000, 1, 32'hD8C7B6A5, 0, 1, 2'd0);
      // 300 consecutive early-sync errors after one clean slot 0.
      beat(8'hE0, 1, 4'b0001, 0, 32'hD8C7B6A5, 0, 1, 2'd1);
      for (int i = 0; i < 300; i++) begin
         beat(8'(i), 1, 4'b0001, 0, 32'hD8C7B6A5, 1, 1, 2'd1);
      end
      idle();
      repeat (3) @(negedge clk);
`ifdef TDM_ERR_CNT_EN
      chk("err_cnt_sat", {24'b0, err_cnt}, 32'd255);
`else
      chk("err_cnt_off", {24'b0, err_cnt}, 32'd0);
`endif
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
